// File: rtl/muldiv_unit.sv
// Iterative signed multiply/divide unit with HI/LO result registers.
// Shift-add multiply and restoring divide on operand magnitudes; signs are applied in FIX.
module muldiv_unit #(
   parameter int unsigned WIDTH     = 32,
   parameter logic [3:0]  MULT_CODE = 4'b0101,
   parameter logic [3:0]  DIV_CODE  = 4'b1011
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       ALU_Control,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int unsigned CW = $clog2(WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

   state_t             r_state, w_state_nxt;
   logic [CW-1:0]      r_cnt;
   logic               r_op_div, r_neg_q, r_neg_r, r_dbz;
   logic [WIDTH-1:0]   r_mag_a, r_mag_b, r_hi, r_lo;
   logic [2*WIDTH-1:0] r_acc;

   logic               w_is_mul, w_is_div, w_accept, w_zero_div, w_last;
   logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_hi_fix, w_lo_fix;
   logic [WIDTH:0]     w_mul_sum, w_div_sh, w_div_diff;
   logic [2*WIDTH-1:0] w_acc_nxt, w_prod;

   assign w_is_mul   = (ALU_Control == MULT_CODE);
   assign w_is_div   = (ALU_Control == DIV_CODE);
   assign w_accept   = (r_state == S_IDLE) && start && (w_is_mul || w_is_div);
   assign w_zero_div = w_is_div && (b == '0);
   assign w_last     = (r_cnt == CW'(WIDTH-1));
   assign w_abs_a    = a[WIDTH-1] ? -a : a;
   assign w_abs_b    = b[WIDTH-1] ? -b : b;

   always_comb begin
      w_state_nxt = r_state;
      busy        = 1'b0;
      done        = 1'b0;
      case (r_state)
         S_IDLE: if (w_accept) w_state_nxt = w_zero_div ? S_DONE : S_RUN;
         S_RUN: begin
            busy = 1'b1;
            if (w_last) w_state_nxt = S_FIX;
         end
         S_FIX: begin
            busy        = 1'b1;
            w_state_nxt = S_DONE;
         end
         S_DONE: begin
            done        = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // r_acc holds {partial product, multiplier} for mult and {remainder, dividend/quotient} for div
   always_comb begin
      w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_mag_a};
      w_div_sh   = r_acc[2*WIDTH-1:WIDTH-1];
      w_div_diff = w_div_sh - {1'b0, r_mag_b};
      w_acc_nxt  = r_acc;
      if (r_op_div) begin
         if (!w_div_diff[WIDTH])
            w_acc_nxt = {w_div_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
         else
            w_acc_nxt = {w_div_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
      end else if (r_acc[0]) begin
         w_acc_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};
      end else begin
         w_acc_nxt = {1'b0, r_acc[2*WIDTH-1:1]};
      end
   end

   always_comb begin
      w_prod   = r_neg_q ? -r_acc : r_acc;
      w_hi_fix = w_prod[2*WIDTH-1:WIDTH];
      w_lo_fix = w_prod[WIDTH-1:0];
      if (r_op_div) begin
         w_lo_fix = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
         w_hi_fix = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_op_div <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_dbz    <= 1'b0;
         r_mag_a  <= '0;
         r_mag_b  <= '0;
         r_acc    <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_op_div <= w_is_div;
                  r_neg_q  <= a[WIDTH-1] ^ b[WIDTH-1];
                  r_neg_r  <= a[WIDTH-1];
                  r_mag_a  <= w_abs_a;
                  r_mag_b  <= w_abs_b;
                  r_cnt    <= '0;
                  r_dbz    <= w_zero_div;
                  r_acc    <= w_is_div ? {{WIDTH{1'b0}}, w_abs_a} : {{WIDTH{1'b0}}, w_abs_b};
               end
            end
            S_RUN: begin
               r_acc <= w_acc_nxt;
               r_cnt <= r_cnt + CW'(1);
            end
            S_FIX: begin
               r_hi <= w_hi_fix;
               r_lo <= w_lo_fix;
            end
            default: ;
         endcase
      end
   end

   assign div_by_zero = r_dbz;
   assign hi          = r_hi;
   assign lo          = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected HI/LO/flag/busy-length pushed at issue, checked on done.
module tb_muldiv_unit;
   localparam logic [3:0] MULT = 4'b0101;
   localparam logic [3:0] DIV  = 4'b1011;
   localparam logic [3:0] ADD  = 4'b0010;

   logic        clk, rst_n, start;
   logic [3:0]  ALU_Control;
   logic [31:0] a, b;
   logic        busy, done, div_by_zero;
   logic [31:0] hi, lo;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dbz;
      int          busy_len;
   } exp_t;

   exp_t        sb[$];
   exp_t        e;
   logic [31:0] m_hi, m_lo;
   int          n_vec, n_err, busy_run;

   muldiv_unit #(.WIDTH(32), .MULT_CODE(MULT), .DIV_CODE(DIV)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .ALU_Control(ALU_Control),
      .a(a), .b(b), .busy(busy), .done(done), .div_by_zero(div_by_zero),
      .hi(hi), .lo(lo)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [3:0] code, input logic [31:0] x, input logic [31:0] y);
      exp_t   r;
      longint sx, sy, p, q, rm;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      r.dbz = 1'b0;
      r.busy_len = 33;
      if (code == MULT) begin
         p    = sx * sy;
         r.hi = p[63:32];
         r.lo = p[31:0];
      end else if (y == 32'd0) begin
         r.hi = m_hi;
         r.lo = m_lo;
         r.dbz = 1'b1;
         r.busy_len = 0;
      end else begin
         q    = sx / sy;
         rm   = sx % sy;
         r.hi = rm[31:0];
         r.lo = q[31:0];
      end
      m_hi = r.hi;
      m_lo = r.lo;
      return r;
   endfunction

   // Output side of the scoreboard
   always @(negedge clk) begin
      if (!rst_n) begin
         busy_run = 0;
      end else begin
         if (busy) busy_run++;
         if (done) begin
            chk("busy_with_done", {63'd0, busy}, 64'd0);
            if (sb.size() == 0) begin
               chk("spurious_done", 64'd1, 64'd0);
            end else begin
               e = sb.pop_front();
               chk("hi", {32'd0, hi}, {32'd0, e.hi});
               chk("lo", {32'd0, lo}, {32'd0, e.lo});
               chk("div_by_zero", {63'd0, div_by_zero}, {63'd0, e.dbz});
               chk("busy_cycles", 64'(busy_run), 64'(e.busy_len));
            end
            busy_run = 0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [3:0] code, input logic [31:0] x, input logic [31:0] y);
      int guard = 0;
      while ((busy || done) && guard < 100) begin
         tick();
         guard++;
      end
      ALU_Control = code;
      a = x;
      b = y;
      start = 1'b1;
      if (code == MULT || code == DIV) sb.push_back(model(code, x, y));
      tick();
      start = 1'b0;
   endtask

   task automatic drain();
      int guard = 0;
      while (sb.size() != 0 && guard < 100) begin
         tick();
         guard++;
      end
      if (sb.size() != 0) begin
         chk("drain_timeout", 64'(sb.size()), 64'd0);
         sb.delete();
      end
      tick();
   endtask

   task automatic wait_done();
      int guard = 0;
      while (!done && guard < 100) begin
         tick();
         guard++;
      end
      if (!done) chk("done_timeout", 64'd0, 64'd1);
   endtask

   initial begin
      n_vec = 0; n_err = 0; busy_run = 0;
      m_hi = '0; m_lo = '0;
      rst_n = 1'b0; start = 1'b0; ALU_Control = '0; a = '0; b = '0;
      tick(); tick();
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      chk("rst_dbz", {63'd0, div_by_zero}, 64'd0);
      chk("rst_hi", {32'd0, hi}, 64'd0);
      chk("rst_lo", {32'd0, lo}, 64'd0);
      rst_n = 1'b1;
      tick();

      issue(MULT, 32'hFFFFFFFD, 32'd7);
      chk("busy_after_accept", {63'd0, busy}, 64'd1);
      drain();
      issue(MULT, 32'h7FFFFFFF, 32'h7FFFFFFF);
      drain();
      issue(DIV, 32'hFFFFFFF9, 32'd2);
      drain();
      issue(DIV, 32'h80000000, 32'hFFFFFFFF);
      drain();

      issue(DIV, 32'h00002211, 32'h00000100);
      drain();
      issue(DIV, 32'd5, 32'd0);
      drain();
      tick(); tick();
      chk("dbz_sticky", {63'd0, div_by_zero}, 64'd1);
      chk("dbz_hi_hold", {32'd0, hi}, 64'h11);
      chk("dbz_lo_hold", {32'd0, lo}, 64'h22);

      issue(ADD, 32'd9, 32'd9);
      chk("add_busy", {63'd0, busy}, 64'd0);
      tick();
      chk("add_busy_later", {63'd0, busy}, 64'd0);
      chk("add_dbz_kept", {63'd0, div_by_zero}, 64'd1);
      chk("add_hi_kept", {32'd0, hi}, 64'h11);

      issue(MULT, 32'd6, 32'hFFFFFFF9);
      chk("dbz_clear_on_accept", {63'd0, div_by_zero}, 64'd0);
      wait_done();
      start = 1'b1;
      ALU_Control = MULT;
      tick();
      start = 1'b0;
      chk("done_start_ignored", {63'd0, busy}, 64'd0);
      tick();
      chk("idle_after_done", {63'd0, busy}, 64'd0);
      drain();

      // start held high with operands and code changing every cycle
      start = 1'b1;
      ALU_Control = DIV;
      a = 32'h8000_1234;
      b = 32'h0000_0777;
      sb.push_back(model(DIV, a, b));
      for (int i = 0; i < 100; i++) begin
         tick();
         if (done) break;
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 2))
            0: ALU_Control = MULT;
            1: ALU_Control = DIV;
            default: ALU_Control = ADD;
         endcase
      end
      start = 1'b0;
      drain();
      chk("held_start_idle", {63'd0, busy}, 64'd0);

      for (int i = 0; i < 8; i++) begin
         logic [31:0] x, y;
         x = $urandom;
         y = (i % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
         if (i == 5) y = 32'hFFFFFF00;
         issue((i % 3 == 0) ? MULT : DIV, x, y);
         drain();
      end

      issue(MULT, 32'h1234_5678, 32'h9ABC_DEF0);
      repeat (9) tick();
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", {63'd0, busy}, 64'd0);
      chk("midrst_done", {63'd0, done}, 64'd0);
      chk("midrst_hi", {32'd0, hi}, 64'd0);
      chk("midrst_lo", {32'd0, lo}, 64'd0);
      sb.delete();
      m_hi = '0; m_lo = '0;
      tick(); tick();
      rst_n = 1'b1;
      repeat (40) tick();
      chk("post_rst_idle", {63'd0, busy}, 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle signed multiply/divide engine that sits directly downstream of the ALU control decoder.
- Consumes the 4-bit ALU control code together with the two register-file operands.
- Executes mult (code 4'b0101) and div (code 4'b1011) iteratively and holds the results in architectural HI/LO registers.
- Exposes a start/busy/done handshake so the control path can stall the pipeline while the unit is running.

Parameters:
- WIDTH, 32, operand width and width of each of HI and LO.
- MULT_CODE, 4'b0101, ALU control code that selects signed multiply.
- DIV_CODE, 4'b1011, ALU control code that selects signed divide.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- ALU_Control  input  4  operation code from the ALU control decoder.
- a  input  WIDTH  operand rs (multiplicand / dividend), two's complement.
- b  input  WIDTH  operand rt (multiplier / divisor), two's complement.
- busy  output  1  high while an accepted operation is in progress.
- done  output  1  one-cycle pulse when HI/LO are valid.
- div_by_zero  output  1  sticky-until-next-accept flag; last div had b==0.
- hi  output  WIDTH  HI register: product[63:32] or remainder.
- lo  output  WIDTH  LO register: product[31:0] or quotient.

Behaviour:
- Reset (rst_n low, asynchronous, any state):
  - state=IDLE; busy=0, done=0, div_by_zero=0, hi=0, lo=0; iteration counter=0.
  - Any in-flight operation is abandoned.
- States:
  - IDLE: waiting for a request.
  - RUN: iterating.
  - FIX: sign correction and HI/LO write.
  - DONE: one-cycle completion.
- Accept:
  - Condition: state==IDLE, start==1, and ALU_Control is MULT_CODE or DIV_CODE.
  - On edge E0: latch |a|, |b|, the result signs and the op; clear div_by_zero; busy=1; counter=0; next state RUN.
- Start with any other code: ignored; no state change; hi/lo untouched.
- Start while busy: ignored; operands of an in-flight op are never changed by inputs.
- Divide by zero (DIV_CODE with b==0) at accept:
  - Go directly IDLE->DONE on E0.
  - div_by_zero=1; hi/lo keep their previous values.
  - done pulses in the cycle after E0; busy=0 in that cycle.
- RUN, one iteration per cycle, 32 cycles (E1..E32); counter increments 0..31; leaves RUN after counter==31.
  - mult: unsigned shift-add on magnitudes into a 64-bit accumulator.
  - div: restoring division on magnitudes, one quotient bit per cycle, MSB first.
- FIX (edge E33):
  - Apply signs and write hi/lo; busy=0; done=1.
  - mult: negate the 64-bit product iff sign(a)!=sign(b); hi=product[63:32], lo=product[31:0].
  - div: quotient negated iff sign(a)!=sign(b); remainder takes the sign of a; lo=quotient, hi=remainder.
  - Overflow -2^31 / -1: lo=0x80000000 (wrap), hi=0, div_by_zero=0.
- DONE: lasts exactly one cycle, then IDLE. A start in this cycle is ignored.
- Latency for a normal op:
  - busy high for 33 cycles.
  - done high only in the cycle after E33.
  - Earliest next accept is 2 cycles after done rises.
- hi/lo change only in FIX, and hold between ops.
- done is never asserted together with busy.

Test Plan:
- Reset mid-op: accept mult, assert rst_n=0 at cycle 10 -> busy=0, done=0, hi=0, lo=0 immediately; no done afterwards.
- Signed mult: a=-3 (0xFFFFFFFD), b=7, start -> busy for 33 cycles, single done pulse; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- Large mult: a=0x7FFFFFFF, b=0x7FFFFFFF -> hi=0x3FFFFFFF, lo=0x00000001.
- Signed div: a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Div by zero: preload hi=0x11, lo=0x22 via a prior op; div a=5, b=0 -> done one cycle after accept, div_by_zero=1, hi/lo unchanged.
- Handshake robustness: start held high continuously with operands changing each cycle, plus start with code 4'b0010 -> only the first mult/div accepted; result matches the operands latched at E0; the add code never sets busy.
